// File: rtl/poliriscv_run_ctrl.sv
// poliriscv_run_ctrl: sequences poliriscv_sc32 through program load, a
// two-cycle core reset, and execution with halt (stable PC) detection.
// Optional watchdog: define POLIRISCV_RUN_CTRL_TIMEOUT_EN to enable the
// TIMEOUT state; when undefined, RUN exits only on halt and timeout_o is 0.
module poliriscv_run_ctrl #(
  parameter int unsigned INSTRUCTIONS    = 1024,
  parameter int unsigned HALT_CYCLES_THR = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 500
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            ld_valid_i,
  input  logic [31:0]                     ld_data_i,
  input  logic                            ld_last_i,
  output logic                            ld_ready_o,
  output logic                            im_we_o,
  output logic [$clog2(INSTRUCTIONS)-1:0] im_waddr_o,
  output logic [31:0]                     im_wdata_o,
  output logic                            cpu_rst_o,
  input  logic [31:0]                     pc_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            timeout_o,
  output logic [31:0]                     run_cycles_o
);

  localparam int unsigned AW = $clog2(INSTRUCTIONS);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(INSTRUCTIONS - 1);
  localparam logic [31:0]   HALT_MATCH = 32'(HALT_CYCLES_THR - 1);
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
  localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
`endif

  // Reject parameter values the counters cannot honour.
  if (HALT_CYCLES_THR < 1) begin : g_bad_thr
    $error("HALT_CYCLES_THR must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RESET,
    S_RUN,
    S_HALT,
    S_TIMEOUT
  } state_e;

  state_e         state_q;
  logic [AW-1:0]  waddr_q;
  logic [AW-1:0]  waddr_d;
  logic           ld_ready_q;
  logic           cpu_rst_q;
  logic           busy_q;
  logic           done_q;
  logic [31:0]    run_cycles_q;
  logic [31:0]    run_cycles_d;
  logic [31:0]    prev_pc_q;
  logic [31:0]    stable_cnt_q;
  logic [31:0]    stable_cnt_d;
  logic           rst_cnt_q;
  logic           ld_accept;
  logic           last_word;
  logic           pc_match;
  logic           halt_hit;
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
  logic           timeout_q;
  logic           timeout_hit;
`endif

  // Handshake and run-phase event decode.
  assign ld_accept = ld_ready_q & ld_valid_i;
  assign last_word = ld_last_i | (waddr_q == LAST_ADDR);
  assign pc_match  = (pc_i == prev_pc_q);
  assign halt_hit  = pc_match & (stable_cnt_q == HALT_MATCH);
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
  assign timeout_hit = (run_cycles_q == TO_LAST);
`endif

  // Next values of the datapath counters; run_cycles saturates at all-ones.
  always_comb begin
    waddr_d      = waddr_q + AW'(1);
    run_cycles_d = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 32'd1;
    stable_cnt_d = pc_match ? stable_cnt_q + 32'd1 : 32'd0;
  end

  // Controller FSM with registered state decodes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      waddr_q      <= '0;
      ld_ready_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      run_cycles_q <= 32'd0;
      prev_pc_q    <= 32'hFFFF_FFFF;
      stable_cnt_q <= 32'd0;
      rst_cnt_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            waddr_q    <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        S_LOAD: begin
          if (ld_accept) begin
            waddr_q <= waddr_d;
            // Final word, or the last memory slot was just written.
            if (last_word) begin
              state_q    <= S_RESET;
              ld_ready_q <= 1'b0;
              rst_cnt_q  <= 1'b0;
            end
          end
        end

        S_RESET: begin
          if (!rst_cnt_q) begin
            rst_cnt_q <= 1'b1;
          end else begin
            state_q      <= S_RUN;
            cpu_rst_q    <= 1'b0;
            prev_pc_q    <= 32'hFFFF_FFFF;
            stable_cnt_q <= 32'd0;
            run_cycles_q <= 32'd0;
          end
        end

        S_RUN: begin
          run_cycles_q <= run_cycles_d;
          prev_pc_q    <= pc_i;
          stable_cnt_q <= stable_cnt_d;
          // Halt takes priority over a simultaneous watchdog expiry.
          if (halt_hit) begin
            state_q   <= S_HALT;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q   <= S_TIMEOUT;
            timeout_q <= 1'b1;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end
`endif
        end

        S_HALT, S_TIMEOUT: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            waddr_q    <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Memory write port is a same-cycle pass-through of the accepted word.
  assign im_we_o      = ld_accept;
  assign im_waddr_o   = waddr_q;
  assign im_wdata_o   = ld_data_i;

  assign ld_ready_o   = ld_ready_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign run_cycles_o = run_cycles_q;
`ifdef POLIRISCV_RUN_CTRL_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule
